// File: rtl/mmio_pkg.sv
// Shared types for the MMIO request/response bus and the two-port arbiter.
package mmio_pkg;

  typedef struct packed {
    logic        is_cached;
    logic        is_aligned;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic        func;
    logic [3:0]  strb;
  } mmio_req_t;

  localparam logic MMIO_RD = 1'b0;
  localparam logic MMIO_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mmio_arbiter_rr_arb2.sv
// Two-way combinational arbiter: one-hot grant from request vector and previous winner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie, in0 wins when fixed or when in1 had the last turn.
      2'b11:   grant = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Merges two MMIO requesters onto one device port with a single outstanding transaction.
//   state | meaning
//   IDLE  | no transaction held, arbitrating between in0/in1
//   REQ   | latched request presented on out_req
//   RESP  | device response routed to the granted requester
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        in0_req_valid,
  output logic        in0_req_ready,
  input  logic        in0_req_bits_is_cached,
  input  logic        in0_req_bits_is_aligned,
  input  logic [31:0] in0_req_bits_addr,
  input  logic [1:0]  in0_req_bits_len,
  input  logic [31:0] in0_req_bits_data,
  input  logic        in0_req_bits_func,
  input  logic [3:0]  in0_req_bits_strb,
  output logic        in0_resp_valid,
  input  logic        in0_resp_ready,
  output logic [31:0] in0_resp_bits_data,

  input  logic        in1_req_valid,
  output logic        in1_req_ready,
  input  logic        in1_req_bits_is_cached,
  input  logic        in1_req_bits_is_aligned,
  input  logic [31:0] in1_req_bits_addr,
  input  logic [1:0]  in1_req_bits_len,
  input  logic [31:0] in1_req_bits_data,
  input  logic        in1_req_bits_func,
  input  logic [3:0]  in1_req_bits_strb,
  output logic        in1_resp_valid,
  input  logic        in1_resp_ready,
  output logic [31:0] in1_resp_bits_data,

  output logic        out_req_valid,
  input  logic        out_req_ready,
  output logic        out_req_bits_is_cached,
  output logic        out_req_bits_is_aligned,
  output logic [31:0] out_req_bits_addr,
  output logic [1:0]  out_req_bits_len,
  output logic [31:0] out_req_bits_data,
  output logic        out_req_bits_func,
  output logic [3:0]  out_req_bits_strb,
  input  logic        out_resp_valid,
  output logic        out_resp_ready,
  input  logic [31:0] out_resp_bits_data
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  mmio_req_t  req_q, req_d;

  mmio_req_t  in0_bits, in1_bits, out_bits;
  logic [1:0] arb_gnt;
  logic       in_idle, in_req, in_resp, sel_resp_ready;

  assign in0_bits = '{is_cached: in0_req_bits_is_cached, is_aligned: in0_req_bits_is_aligned,
                      addr: in0_req_bits_addr, len: in0_req_bits_len, data: in0_req_bits_data,
                      func: in0_req_bits_func, strb: in0_req_bits_strb};
  assign in1_bits = '{is_cached: in1_req_bits_is_cached, is_aligned: in1_req_bits_is_aligned,
                      addr: in1_req_bits_addr, len: in1_req_bits_len, data: in1_req_bits_data,
                      func: in1_req_bits_func, strb: in1_req_bits_strb};

  rr_arb2 u_arb (
    .req        ({in1_req_valid, in0_req_valid}),
    .last_grant (last_grant_q),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (arb_gnt)
  );

  // Every handshake output is qualified by reset so nothing leaks while it is held low.
  assign in_idle        = reset && (state_q == IDLE);
  assign in_req         = reset && (state_q == REQ);
  assign in_resp        = reset && (state_q == RESP);
  assign sel_resp_ready = grant_q ? in1_resp_ready : in0_resp_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          grant_d      = arb_gnt[1];
          last_grant_d = arb_gnt[1];
          req_d        = arb_gnt[1] ? in1_bits : in0_bits;
          state_d      = REQ;
        end
      end
      REQ:     if (out_req_ready) state_d = RESP;
      RESP:    if (out_resp_valid && sel_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      req_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
    end
  end

  assign in0_req_ready = in_idle && arb_gnt[0];
  assign in1_req_ready = in_idle && arb_gnt[1];

  assign out_bits                = reset ? req_q : '0;
  assign out_req_valid           = in_req;
  assign out_req_bits_is_cached  = out_bits.is_cached;
  assign out_req_bits_is_aligned = out_bits.is_aligned;
  assign out_req_bits_addr       = out_bits.addr;
  assign out_req_bits_len        = out_bits.len;
  assign out_req_bits_data       = out_bits.data;
  assign out_req_bits_func       = out_bits.func;
  assign out_req_bits_strb       = out_bits.strb;

  assign in0_resp_valid     = in_resp && !grant_q && out_resp_valid;
  assign in1_resp_valid     = in_resp &&  grant_q && out_resp_valid;
  assign in0_resp_bits_data = (in_resp && !grant_q) ? out_resp_bits_data : 32'h0;
  assign in1_resp_bits_data = (in_resp &&  grant_q) ? out_resp_bits_data : 32'h0;
  assign out_resp_ready     = in_resp && sel_resp_ready;

endmodule
